// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt controller and its CPU/peripheral side.
// The CPU side uses the master modport and the controller uses the slave modport.
interface irq_controller_if;
    logic [3:0]  irq_src;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [3:0]  mask;
    logic [3:0]  pending;
    logic [3:0]  in_service;
    logic        irq_req;
    logic [1:0]  irq_id;
    logic [31:0] irq_vec;
    logic        irq_ack;
    logic        eoi;

    modport master (
        output irq_src, mask_we, mask_wdata, irq_ack, eoi,
        input  mask, pending, in_service, irq_req, irq_id, irq_vec
    );

    modport slave (
        input  irq_src, mask_we, mask_wdata, irq_ack, eoi,
        output mask, pending, in_service, irq_req, irq_id, irq_vec
    );
endinterface

// File: rtl/irq_controller.sv
// Four-source fixed-priority interrupt controller with req/ack/eoi handshake.
// Optional preemption of a lower in-service level is enabled by defining IRQ_NESTING_EN.
module irq_controller #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0800
) (
    input  logic             clk,
    input  logic             rst_n,
    irq_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  prev_r;
    logic [3:0]  pending_r;
    logic [3:0]  mask_r;
    logic [3:0]  in_service_r;
    logic [1:0]  id_r;
    logic        irq_req_r;

    logic [3:0]  rise_s;
    logic [3:0]  eligible_s;
    logic [1:0]  win_id_s;
    logic [1:0]  top_isv_s;
    logic [3:0]  id_bit_s;
    logic [3:0]  top_bit_s;
    logic        ack_take_s;
    logic        eoi_take_s;
    logic        preempt_s;

    // Index of the highest set bit; source 3 has the highest priority.
    function automatic logic [1:0] top_index(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Edge detection, arbitration and handshake qualification.
    always_comb begin
        rise_s     = bus.irq_src & ~prev_r;
        eligible_s = pending_r & ~mask_r;
        win_id_s   = top_index(eligible_s);
        top_isv_s  = top_index(in_service_r);
        id_bit_s   = 4'b0001 << id_r;
        top_bit_s  = 4'b0001 << top_isv_s;
        ack_take_s = (state_r == ST_REQ) && bus.irq_ack;
        eoi_take_s = (state_r == ST_SERV) && bus.eoi;
`ifdef IRQ_NESTING_EN
        if ((state_r == ST_SERV) && !bus.eoi && (eligible_s != 4'b0000) && (win_id_s > top_isv_s)) begin
            preempt_s = 1'b1;
        end else begin
            preempt_s = 1'b0;
        end
`else
        preempt_s = 1'b0;
`endif
    end

    // Request latching, mask register and in-service bookkeeping; a same-edge rise beats the ack clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r       <= 4'b0000;
            pending_r    <= 4'b0000;
            mask_r       <= 4'b1111;
            in_service_r <= 4'b0000;
        end else begin
            prev_r <= bus.irq_src;
            if (ack_take_s) begin
                pending_r    <= (pending_r & ~id_bit_s) | rise_s;
                in_service_r <= in_service_r | id_bit_s;
            end else if (eoi_take_s) begin
                pending_r    <= pending_r | rise_s;
                in_service_r <= in_service_r & ~top_bit_s;
            end else begin
                pending_r    <= pending_r | rise_s;
                in_service_r <= in_service_r;
            end
            if (bus.mask_we) begin
                mask_r <= bus.mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Handshake FSM; a withdrawn request falls back to SERV when a lower level is still in service.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            id_r      <= 2'd0;
            irq_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (eligible_s != 4'b0000) begin
                        id_r      <= win_id_s;
                        state_r   <= ST_REQ;
                        irq_req_r <= 1'b1;
                    end else begin
                        irq_req_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bus.irq_ack) begin
                        state_r   <= ST_SERV;
                        irq_req_r <= 1'b0;
                    end else if (!eligible_s[id_r]) begin
                        state_r   <= (in_service_r != 4'b0000) ? ST_SERV : ST_IDLE;
                        irq_req_r <= 1'b0;
                    end else begin
                        irq_req_r <= 1'b1;
                    end
                end
                ST_SERV: begin
                    if (eoi_take_s) begin
                        if ((in_service_r & ~top_bit_s) == 4'b0000) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_SERV;
                        end
                        irq_req_r <= 1'b0;
                    end else if (preempt_s) begin
                        id_r      <= win_id_s;
                        state_r   <= ST_REQ;
                        irq_req_r <= 1'b1;
                    end else begin
                        irq_req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    irq_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mask       = mask_r;
    assign bus.pending    = pending_r;
    assign bus.in_service = in_service_r;
    assign bus.irq_req    = irq_req_r;
    assign bus.irq_id     = id_r;
    assign bus.irq_vec    = VEC_BASE + {28'd0, id_r, 2'b00};

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the interrupt rules.
module tb_irq_controller;

    localparam logic [31:0] VB = 32'h0000_0800;
`ifdef IRQ_NESTING_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    irq_controller_if bus();

    irq_controller #(.VEC_BASE(VB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: phase 0 = idle, 1 = requesting, 2 = serving.
    bit [3:0] m_prev, m_pend, m_mask, m_isv;
    int       m_phase;
    int       m_id;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int highest(input bit [3:0] v);
        int h = -1;
        for (int i = 0; i < 4; i++) if (v[i]) h = i;
        return h;
    endfunction

    task automatic model_reset();
        m_prev  = 4'b0000;
        m_pend  = 4'b0000;
        m_mask  = 4'b1111;
        m_isv   = 4'b0000;
        m_phase = 0;
        m_id    = 0;
    endtask

    task automatic model_step();
        bit [3:0] src, wd, elig;
        bit       we, ack, eo;
        int       best, top;
        src  = bus.irq_src;
        we   = bus.mask_we;
        wd   = bus.mask_wdata;
        ack  = bus.irq_ack;
        eo   = bus.eoi;
        elig = m_pend & ~m_mask;
        best = highest(elig);
        top  = highest(m_isv);
        case (m_phase)
            0: if (best >= 0) begin m_id = best; m_phase = 1; end
            1: begin
                if (ack) begin
                    m_pend[m_id] = 1'b0;
                    m_isv[m_id]  = 1'b1;
                    m_phase      = 2;
                end else if (!elig[m_id]) begin
                    m_phase = (m_isv != 4'b0000) ? 2 : 0;
                end
            end
            default: begin
                if (eo && top >= 0) begin
                    m_isv[top] = 1'b0;
                    if (m_isv == 4'b0000) m_phase = 0;
                end else if (NEST && best > top) begin
                    m_id    = best;
                    m_phase = 1;
                end
            end
        endcase
        for (int i = 0; i < 4; i++) if (src[i] && !m_prev[i]) m_pend[i] = 1'b1;
        m_prev = src;
        if (we) m_mask = wd;
    endtask

    task automatic check_all();
        check_val("mask", {28'd0, bus.mask}, {28'd0, m_mask});
        check_val("pending", {28'd0, bus.pending}, {28'd0, m_pend});
        check_val("in_service", {28'd0, bus.in_service}, {28'd0, m_isv});
        check_val("irq_req", {31'd0, bus.irq_req}, (m_phase == 1) ? 32'd1 : 32'd0);
        if (m_phase == 1) check_val("irq_id", {30'd0, bus.irq_id}, m_id);
        check_val("irq_vec", bus.irq_vec, VB + 32'(4 * m_id));
    endtask

    task automatic drive(input logic [3:0] src, input logic we, input logic [3:0] wd,
                         input logic ack, input logic eo);
        bus.irq_src    = src;
        bus.mask_we    = we;
        bus.mask_wdata = wd;
        bus.irq_ack    = ack;
        bus.eoi        = eo;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit [3:0] src_r;
        bit [3:0] wd_r;
        bit       we_r, ack_r, eoi_r;

        do_reset();
        check_val("rst_vec", bus.irq_vec, 32'h0000_0800);
        check_val("rst_mask", {28'd0, bus.mask}, 32'hf);

        // Basic request/ack/eoi on source 1.
        drive(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0); tick();
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        check_val("s1_pend", {28'd0, bus.pending}, 32'h2);
        check_val("s1_noreq_yet", {31'd0, bus.irq_req}, 32'd0);
        tick();
        check_val("s1_req", {31'd0, bus.irq_req}, 32'd1);
        check_val("s1_id", {30'd0, bus.irq_id}, 32'd1);
        check_val("s1_vec", bus.irq_vec, 32'h0000_0804);
        drive(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        check_val("s1_ack_pend", {28'd0, bus.pending}, 32'h0);
        check_val("s1_ack_isv", {28'd0, bus.in_service}, 32'h2);
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
        check_val("s1_eoi_isv", {28'd0, bus.in_service}, 32'h0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();

        // Simultaneous rises on 0 and 2: 2 wins, then 0.
        drive(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0); tick(); tick();
        check_val("s02_id2", {30'd0, bus.irq_id}, 32'd2);
        drive(4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        drive(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
        drive(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        check_val("s02_req0", {31'd0, bus.irq_req}, 32'd1);
        check_val("s02_vec0", bus.irq_vec, 32'h0000_0800);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();

        // Masked source 3, unmask, re-mask before ack.
        drive(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0); tick();
        drive(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0); tick(); tick();
        check_val("s3_masked_noreq", {31'd0, bus.irq_req}, 32'd0);
        drive(4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0); tick();
        drive(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        check_val("s3_unmask_req", {31'd0, bus.irq_req}, 32'd1);
        check_val("s3_id", {30'd0, bus.irq_id}, 32'd3);
        drive(4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0); tick();
        drive(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        check_val("s3_remask_drop", {31'd0, bus.irq_req}, 32'd0);
        check_val("s3_still_pend", {28'd0, bus.pending & 4'b1000}, 32'h8);
        drive(4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0); tick();
        drive(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        drive(4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        drive(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();

        // Rise on source 1 in the same cycle as its ack: set wins.
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        drive(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        check_val("same_edge_pend", {28'd0, bus.pending}, 32'h2);
        check_val("same_edge_isv", {28'd0, bus.in_service}, 32'h2);
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        check_val("same_edge_rereq", {31'd0, bus.irq_req}, 32'd1);
        check_val("same_edge_id", {30'd0, bus.irq_id}, 32'd1);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();

        // Source 0 in service, source 3 arrives.
        drive(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0); tick(); tick();
        drive(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        drive(4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
`ifdef IRQ_NESTING_EN
        check_val("nest_req", {31'd0, bus.irq_req}, 32'd1);
        check_val("nest_id", {30'd0, bus.irq_id}, 32'd3);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        check_val("nest_isv2", {28'd0, bus.in_service}, 32'h9);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
        check_val("nest_eoi1", {28'd0, bus.in_service}, 32'h1);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        check_val("nest_stay", {31'd0, bus.irq_req}, 32'd0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
        check_val("nest_eoi2", {28'd0, bus.in_service}, 32'h0);
`else
        check_val("flat_wait", {31'd0, bus.irq_req}, 32'd0);
        check_val("flat_pend3", {28'd0, bus.pending}, 32'h8);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
        check_val("flat_eoi", {28'd0, bus.in_service}, 32'h0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();
        check_val("flat_req3", {30'd0, bus.irq_id}, 32'd3);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0); tick();
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); tick();
`endif
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); tick();

        // Asynchronous reset while requesting.
        drive(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0); tick(); tick();
        check_val("pre_rst_req", {31'd0, bus.irq_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_req", {31'd0, bus.irq_req}, 32'd0);
        check_val("async_mask", {28'd0, bus.mask}, 32'hf);
        check_val("async_pend", {28'd0, bus.pending}, 32'h0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        src_r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            src_r = src_r ^ (4'($urandom) & 4'($urandom));
            we_r  = ($urandom_range(0, 7) == 0);
            wd_r  = 4'($urandom) & 4'($urandom);
            ack_r = (m_phase == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            eoi_r = ($urandom_range(0, 3) == 0);
            drive(src_r, we_r, wd_r, ack_r, eoi_r);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
